// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word read or byte-masked write at a time,
// waits a programmable access delay, then returns data or a write acknowledge.
module mem_responder #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [3:0]       req_wstrb,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_is_write
);

    localparam int WORD_BITS = ADDR_WIDTH - 2;
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_r;
    logic [3:0]           cnt_r;
    logic                 we_r;
    logic [WORD_BITS-1:0] word_r;
    logic [WIDTH-1:0]     wdata_r;
    logic [3:0]           wstrb_r;
    logic                 resp_valid_r;
    logic [WIDTH-1:0]     resp_rdata_r;
    logic                 resp_is_write_r;

    logic [7:0]           mem_r [DEPTH];

    logic                 accept_s;
    logic                 exec_s;
    logic                 acc_we_s;
    logic [WORD_BITS-1:0] acc_word_s;
    logic [WIDTH-1:0]     acc_wdata_s;
    logic [3:0]           acc_wstrb_s;
    logic [WIDTH-1:0]     rdata_s;
    logic                 unused_s;

    assign unused_s  = ^{req_addr[WIDTH-1:ADDR_WIDTH], req_addr[1:0]};
    assign req_ready = (state_r == ST_IDLE);
    assign accept_s  = req_valid && req_ready;

    // Select the access operands: live request for a zero-latency accept, latched copy otherwise
    always_comb begin
        acc_we_s    = we_r;
        acc_word_s  = word_r;
        acc_wdata_s = wdata_r;
        acc_wstrb_s = wstrb_r;
        exec_s      = 1'b0;
        if (state_r == ST_IDLE) begin
            acc_we_s    = req_we;
            acc_word_s  = req_addr[ADDR_WIDTH-1:2];
            acc_wdata_s = req_wdata;
            acc_wstrb_s = req_wstrb;
            exec_s      = accept_s && (LATENCY == 0);
        end else begin
            exec_s      = (state_r == ST_BUSY) && (cnt_r == 4'd0);
        end
    end

    // Little-endian word read from the byte array
    always_comb begin
        rdata_s = '0;
        for (int i = 0; i < 4; i++) begin
            rdata_s[8*i +: 8] = mem_r[{acc_word_s, 2'(i)}];
        end
    end

    // Byte-lane writes commit only at the execution edge and never while reset is held
    always_ff @(posedge clk) begin
        if (exec_s && acc_we_s && rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb_s[i]) begin
                    mem_r[{acc_word_s, 2'(i)}] <= acc_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM with latched request and registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            cnt_r           <= 4'd0;
            we_r            <= 1'b0;
            word_r          <= '0;
            wdata_r         <= '0;
            wstrb_r         <= 4'd0;
            resp_valid_r    <= 1'b0;
            resp_rdata_r    <= '0;
            resp_is_write_r <= 1'b0;
        end else begin
            if (exec_s) begin
                state_r         <= ST_RESP;
                resp_valid_r    <= 1'b1;
                resp_rdata_r    <= acc_we_s ? '0 : rdata_s;
                resp_is_write_r <= acc_we_s;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            we_r    <= req_we;
                            word_r  <= req_addr[ADDR_WIDTH-1:2];
                            wdata_r <= req_wdata;
                            wstrb_r <= req_wstrb;
                            cnt_r   <= LAT_LOAD;
                            state_r <= ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                    ST_RESP: begin
                        if (resp_ready) begin
                            state_r      <= ST_IDLE;
                            resp_valid_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign resp_valid    = resp_valid_r;
    assign resp_rdata    = resp_rdata_r;
    assign resp_is_write = resp_is_write_r;

endmodule
